calc2_dispatch_arb: RTL

- Scheduler that shares the calc2 adder and shifter between the four request ports.
- Sits between the per-port hold registers and the two ALU input stages.
- Each cycle it selects at most one request for the adder and at most one for the shifter, using independent round-robin pointers.
- It keeps a per-port tag scoreboard, so a tag cannot be reissued while still outstanding. Invalid commands go straight to the port's error response path.

---
 rtl/calc2_dispatch_arb.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/calc2_dispatch_arb.sv
// calc2_dispatch_arb: shares the calc2 adder and shifter between four
// request ports with independent round-robin pointers and a per-port
// tag scoreboard. Invalid commands are acked and reported on inv_*.
//
// Ports:
//   c_clk, reset            clock, synchronous active-high reset
//   req_cmd_in/req_tag_in   per-port command (4b) and tag (2b)
//   req_ack                 per-port request consumed (grant or invalid)
//   add_* / shf_*           one-cycle grant to adder / shifter stage
//   inv_vld/inv_tag         per-port invalid-command pulse and its tag
//   done_vld/done_tag       per-port completion, frees scoreboard bit
//   busy_map                scoreboard, bit 4p+t = port p tag t in flight
//   err_stray               sticky: completion for a tag not in flight
module calc2_dispatch_arb (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [15:0] req_cmd_in,
    input  logic [7:0]  req_tag_in,
    output logic [3:0]  req_ack,
    output logic        add_vld,
    output logic [1:0]  add_port,
    output logic [3:0]  add_cmd,
    output logic [1:0]  add_tag,
    output logic        shf_vld,
    output logic [1:0]  shf_port,
    output logic [3:0]  shf_cmd,
    output logic [1:0]  shf_tag,
    output logic [3:0]  inv_vld,
    output logic [7:0]  inv_tag,
    input  logic [3:0]  done_vld,
    input  logic [7:0]  done_tag,
    output logic [15:0] busy_map,
    output logic        err_stray
);

    localparam int NPORT = 4;

    logic [3:0]  w_is_add;
    logic [3:0]  w_is_shf;
    logic [3:0]  w_is_inv;
    logic [3:0]  w_add_elig;
    logic [3:0]  w_shf_elig;
    logic [7:0]  w_inv_tag;

    logic [3:0]  r_ack;
    logic        r_add_vld;
    logic [1:0]  r_add_port;
    logic [3:0]  r_add_cmd;
    logic [1:0]  r_add_tag;
    logic        r_shf_vld;
    logic [1:0]  r_shf_port;
    logic [3:0]  r_shf_cmd;
    logic [1:0]  r_shf_tag;
    logic [3:0]  r_inv_vld;
    logic [7:0]  r_inv_tag;
    logic [15:0] r_busy;
    logic        r_err;
    logic [1:0]  r_add_ptr;
    logic [1:0]  r_shf_ptr;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [3:0] w_cmd;
        logic [1:0] w_tag;
        logic [3:0] w_pbusy;
        logic       w_hit;
        assign w_cmd   = req_cmd_in[4*p +: 4];
        assign w_tag   = req_tag_in[2*p +: 2];
        assign w_pbusy = r_busy[4*p +: 4];
        assign w_hit   = w_pbusy[w_tag];
        assign w_is_add[p] = (w_cmd == 4'd1) || (w_cmd == 4'd2);
        assign w_is_shf[p] = (w_cmd == 4'd5) || (w_cmd == 4'd6);
        assign w_is_inv[p] = (w_cmd != 4'd0) && !w_is_add[p] && !w_is_shf[p];
        // Invalid ops bypass the scoreboard; only real issues stall on it.
        assign w_add_elig[p] = w_is_add[p] && !w_hit;
        assign w_shf_elig[p] = w_is_shf[p] && !w_hit;
        assign w_inv_tag[2*p +: 2] = w_is_inv[p] ? w_tag : 2'd0;
    end

    // Returns {found, port}: first eligible port scanning ptr, ptr+1, ...
    // Scanning backwards lets the closest-to-ptr hit overwrite the rest.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig,
                                           input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = NPORT - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (elig[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    logic [2:0] w_add_pick;
    logic [2:0] w_shf_pick;
    logic       w_add_fnd;
    logic       w_shf_fnd;
    logic [1:0] w_add_idx;
    logic [1:0] w_shf_idx;
    logic [1:0] w_add_tag;
    logic [1:0] w_shf_tag;
    logic [3:0] w_add_cmd;
    logic [3:0] w_shf_cmd;
    logic [3:0] w_ack;
    logic [15:0] w_set;
    logic [15:0] w_clr;
    logic        w_stray;

    assign w_add_pick = rr_pick(w_add_elig, r_add_ptr);
    assign w_shf_pick = rr_pick(w_shf_elig, r_shf_ptr);
    assign w_add_fnd  = w_add_pick[2];
    assign w_shf_fnd  = w_shf_pick[2];
    assign w_add_idx  = w_add_pick[1:0];
    assign w_shf_idx  = w_shf_pick[1:0];
    assign w_add_cmd  = req_cmd_in[{w_add_idx, 2'b00} +: 4];
    assign w_shf_cmd  = req_cmd_in[{w_shf_idx, 2'b00} +: 4];
    assign w_add_tag  = req_tag_in[{w_add_idx, 1'b0} +: 2];
    assign w_shf_tag  = req_tag_in[{w_shf_idx, 1'b0} +: 2];

    assign w_ack = w_is_inv
                 | ({3'b000, w_add_fnd} << w_add_idx)
                 | ({3'b000, w_shf_fnd} << w_shf_idx);

    assign w_set = ({15'd0, w_add_fnd} << {w_add_idx, w_add_tag})
                 | ({15'd0, w_shf_fnd} << {w_shf_idx, w_shf_tag});

    always_comb begin
        w_clr   = '0;
        w_stray = 1'b0;
        for (int p = 0; p < NPORT; p++) begin
            if (done_vld[p]) begin
                w_clr[{2'(p), done_tag[2*p +: 2]}] = 1'b1;
                if (!r_busy[{2'(p), done_tag[2*p +: 2]}]) w_stray = 1'b1;
            end
        end
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_ack      <= '0;
            r_add_vld  <= 1'b0;
            r_add_port <= '0;
            r_add_cmd  <= '0;
            r_add_tag  <= '0;
            r_shf_vld  <= 1'b0;
            r_shf_port <= '0;
            r_shf_cmd  <= '0;
            r_shf_tag  <= '0;
            r_inv_vld  <= '0;
            r_inv_tag  <= '0;
            r_busy     <= '0;
            r_err      <= 1'b0;
            r_add_ptr  <= '0;
            r_shf_ptr  <= '0;
        end else begin
            r_ack      <= w_ack;
            r_add_vld  <= w_add_fnd;
            r_add_port <= w_add_fnd ? w_add_idx : 2'd0;
            r_add_cmd  <= w_add_fnd ? w_add_cmd : 4'd0;
            r_add_tag  <= w_add_fnd ? w_add_tag : 2'd0;
            r_shf_vld  <= w_shf_fnd;
            r_shf_port <= w_shf_fnd ? w_shf_idx : 2'd0;
            r_shf_cmd  <= w_shf_fnd ? w_shf_cmd : 4'd0;
            r_shf_tag  <= w_shf_fnd ? w_shf_tag : 2'd0;
            r_inv_vld  <= w_is_inv;
            r_inv_tag  <= w_inv_tag;
            // Set after clear: a same-cycle reissue keeps the bit busy.
            r_busy     <= (r_busy & ~w_clr) | w_set;
            r_err      <= r_err | w_stray;
            if (w_add_fnd) r_add_ptr <= w_add_idx + 2'd1;
            if (w_shf_fnd) r_shf_ptr <= w_shf_idx + 2'd1;
        end
    end

    assign req_ack   = r_ack;
    assign add_vld   = r_add_vld;
    assign add_port  = r_add_port;
    assign add_cmd   = r_add_cmd;
    assign add_tag   = r_add_tag;
    assign shf_vld   = r_shf_vld;
    assign shf_port  = r_shf_port;
    assign shf_cmd   = r_shf_cmd;
    assign shf_tag   = r_shf_tag;
    assign inv_vld   = r_inv_vld;
    assign inv_tag   = r_inv_tag;
    assign busy_map  = r_busy;
    assign err_stray = r_err;

endmodule
